// File: rtl/f_fetch_pkg.sv
// Shared types and defaults for the F-stage fetch sequencer.
package f_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT = 4096;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // RUN: normal sequential fetch. SLOT: one delay-slot fetch owed at the old PC.
    typedef enum logic {
        RUN  = 1'b0,
        SLOT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } q_entry_t;

    // Branch targets are word addresses; stray low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/f_fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries between the IM ROM and D.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module f_fetch_queue
    import f_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     push,
    input  q_entry_t                 push_data,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     keep_head,
    output q_entry_t                 head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] rd_ptr;
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_next;
    logic [PW:0] wr_base;
    q_entry_t    mem [DEPTH];

    // Pointer targets for this cycle; a flush keeps at most the oldest surviving entry.
    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path leaves it
        // unassigned and no latch is inferred.
        rd_next = rd_ptr + {{PW{1'b0}}, pop};
        wr_base = wr_ptr;
        if (flush) begin
            wr_base = keep_head ? rd_next + (PW+1)'(1) : rd_next;
        end
    end

    // Pointer registers; any push lands after the (possibly flushed) tail.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values, independent of block ordering.
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_base + {{PW{1'b0}}, push};
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset; an entry is only observed once count
        // says it holds data, so clearing it would buy nothing.
        if (push) begin
            mem[wr_base[PW-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/f_fetch_sequencer.sv
// F-stage PC owner: issues synchronous-read IM fetches, queues the returned words and
// hands them to D with valid/ready, handling D redirects and the MIPS delay slot.
module f_fetch_sequencer
    import f_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IM_WORDS   = IM_WORDS_DEFAULT,
    parameter int          QDEPTH     = 4,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        D_READY,
    output logic        D_VALID,
    output logic [31:0] D_PC,
    output logic [31:0] D_INSTR,
    output logic        IM_EN,
    output logic [11:0] IM_ADDR,
    input  logic [31:0] IM_RDATA
);

    localparam int          CW       = $clog2(QDEPTH) + 1;
    localparam logic [31:0] IM_BYTES = 32'(IM_WORDS) << 2;

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_n;
    logic [31:0]   slot_target;
    logic [31:0]   slot_target_n;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_oor;

    logic [CW-1:0] q_count;
    q_entry_t      q_head;
    q_entry_t      q_push_data;
    logic          q_push;
    logic          q_pop;
    logic          q_flush;
    logic          q_keep;

    logic          issue;
    logic          d_valid;
    logic          in_range;
    logic [31:0]   fetch_off;
    logic [31:0]   target;
    logic [CW:0]   occupancy;
    logic [CW-1:0] remaining;

    assign d_valid   = (q_count != '0);
    assign q_pop     = d_valid & D_READY;
    assign fetch_off = fetch_pc - RESET_PC;
    // Unsigned offset: PCs below the ROM base wrap high and count as out of range.
    assign in_range  = (fetch_off < IM_BYTES);
    assign target    = word_align(REDIRECT_PC);
    // Slots already claimed: queued + returning now, minus the one D takes this cycle.
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, q_pop};
    assign remaining = q_count - {{(CW-1){1'b0}}, q_pop};
    // Out-of-range fetches never touched the ROM, so they return a nop.
    assign q_push_data = {inflight_pc, (inflight_oor ? NOP : IM_RDATA)};

    // Next-state, issue and queue-control decisions for the current cycle.
    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        slot_target_n = slot_target;
        issue         = 1'b0;
        q_push        = 1'b0;
        q_flush       = 1'b0;
        q_keep        = 1'b0;
        case (state)
            RUN: begin
                if (REDIRECT) begin
                    // Hold issue: fetch_pc is past the delay slot or about to be replaced.
                    if (!DELAY_SLOT) begin
                        q_flush    = 1'b1;
                        fetch_pc_n = target;
                    end else if (remaining != '0) begin
                        // Oldest surviving queue entry is the delay slot; returning fetch dies.
                        q_flush    = 1'b1;
                        q_keep     = 1'b1;
                        fetch_pc_n = target;
                    end else if (inflight) begin
                        // Queue drains this cycle; the returning word is the delay slot.
                        q_push     = 1'b1;
                        fetch_pc_n = target;
                    end else begin
                        // Delay slot not fetched yet: fetch it next cycle, then jump.
                        state_n       = SLOT;
                        slot_target_n = target;
                    end
                end else begin
                    // RESET_N gate keeps IM_EN low while the block is held in reset.
                    issue  = RESET_N && (occupancy < (CW+1)'(QDEPTH));
                    q_push = inflight;
                    if (issue) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                    end
                end
            end
            SLOT: begin
                // Queue is empty with nothing in flight here, so the forced issue has room.
                issue      = 1'b1;
                q_push     = inflight;
                fetch_pc_n = REDIRECT ? target : slot_target;
                state_n    = RUN;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // Fetch state: PC, pending-slot target and the one-deep in-flight tracker.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= RUN;
            fetch_pc     <= RESET_PC;
            slot_target  <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_oor <= 1'b0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            slot_target  <= slot_target_n;
            inflight     <= issue;
            inflight_pc  <= fetch_pc;
            inflight_oor <= ~in_range;
        end
    end

    f_fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (q_flush),
        .keep_head (q_keep),
        .head      (q_head),
        .count     (q_count)
    );

    assign IM_EN   = issue & in_range;
    assign IM_ADDR = fetch_off[13:2];
    assign D_VALID = d_valid;
    assign D_PC    = d_valid ? q_head.pc    : '0;
    assign D_INSTR = d_valid ? q_head.instr : '0;

endmodule

// File: tb/tb_f_fetch_sequencer.sv
// Bench for f_fetch_sequencer: one DELAY_SLOT=1 and one DELAY_SLOT=0 instance share the
// stimulus; each has its own ROM and a program-order reference model of what D must see.
module tb_f_fetch_sequencer;

    localparam logic [31:0] BASE     = 32'h0000_3000;
    localparam logic [31:0] SPAN     = 32'h0000_4000;
    localparam int          QD       = 4;
    localparam int          WD_LIMIT = 6;

    logic        CLK;
    logic        RESET_N;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        D_READY;

    logic [1:0]  d_valid;
    logic [1:0]  im_en;
    logic [31:0] d_pc     [2];
    logic [31:0] d_instr  [2];
    logic [31:0] im_rdata [2];
    logic [11:0] im_addr  [2];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: next program-order PC, and a pending delay-slot PC if one is owed.
    logic [31:0] m_seq  [2];
    logic        m_pend [2];
    logic [31:0] m_slot [2];
    int          wd     [2];

    f_fetch_sequencer #(.DELAY_SLOT(1'b1)) u_ds1 (
        .CLK(CLK), .RESET_N(RESET_N), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .D_READY(D_READY), .D_VALID(d_valid[0]), .D_PC(d_pc[0]), .D_INSTR(d_instr[0]),
        .IM_EN(im_en[0]), .IM_ADDR(im_addr[0]), .IM_RDATA(im_rdata[0])
    );

    f_fetch_sequencer #(.DELAY_SLOT(1'b0)) u_ds0 (
        .CLK(CLK), .RESET_N(RESET_N), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .D_READY(D_READY), .D_VALID(d_valid[1]), .D_PC(d_pc[1]), .D_INSTR(d_instr[1]),
        .IM_EN(im_en[1]), .IM_ADDR(im_addr[1]), .IM_RDATA(im_rdata[1])
    );

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {8'hA5, a, a ^ 12'h3C3};
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - BASE;
        if (off < SPAN) return rom_word(off[13:2]);
        return 32'h0000_0000;
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous ROMs; garbage on the bus when not enabled.
    always @(posedge CLK) im_rdata[0] <= im_en[0] ? rom_word(im_addr[0]) : $urandom;
    always @(posedge CLK) im_rdata[1] <= im_en[1] ? rom_word(im_addr[1]) : $urandom;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_seq[k]  = BASE;
            m_pend[k] = 1'b0;
            m_slot[k] = BASE;
            wd[k]     = 0;
        end
    endtask

    // Set this cycle's inputs just after the falling edge, then settle.
    task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
        D_READY     = rdy;
        REDIRECT    = rd;
        REDIRECT_PC = rpc;
        #1;
    endtask

    // Score this cycle's pop and redirect against the model, then move to the next falling edge.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            logic        pop_k;
            logic [31:0] e;
            pop_k = d_valid[k] && D_READY;
            if (pop_k) begin
                if (m_pend[k]) begin
                    e         = m_slot[k];
                    m_pend[k] = 1'b0;
                end else begin
                    e        = m_seq[k];
                    m_seq[k] = m_seq[k] + 32'd4;
                end
                check($sformatf("pop_pc_u%0d", k), d_pc[k], e);
                check($sformatf("pop_instr_u%0d", k), d_instr[k], exp_instr(e));
            end
            if (REDIRECT) begin
                if (k == 0) begin
                    if (!m_pend[k]) begin
                        m_pend[k] = 1'b1;
                        m_slot[k] = m_seq[k];
                    end
                end else begin
                    m_pend[k] = 1'b0;
                end
                m_seq[k] = REDIRECT_PC & ~32'h0000_0003;
            end
            if (D_READY && !REDIRECT && !pop_k) wd[k]++;
            else wd[k] = 0;
            if (wd[k] >= WD_LIMIT) begin
                check($sformatf("liveness_u%0d", k), 32'(wd[k]), 32'(WD_LIMIT - 1));
                wd[k] = 0;
            end
        end
        @(negedge CLK);
    endtask

    // Assert reset now, check the cleared outputs, release on a falling edge.
    task automatic do_reset();
        D_READY     = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        RESET_N     = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_d_valid_u%0d", k), 32'(d_valid[k]), 32'd0);
            check($sformatf("rst_d_pc_u%0d", k), d_pc[k], 32'd0);
            check($sformatf("rst_d_instr_u%0d", k), d_instr[k], 32'd0);
            check($sformatf("rst_im_en_u%0d", k), 32'(im_en[k]), 32'd0);
            check($sformatf("rst_im_addr_u%0d", k), 32'(im_addr[k]), 32'd0);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    initial begin
        RESET_N     = 1'b1;
        D_READY     = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        model_reset();
        #2;
        do_reset();

        // Free-running fetch from reset: one fetch and, from cycle 2, one delivery per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, '0);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("t1_im_en_u%0d", k), 32'(im_en[k]), 32'd1);
                check($sformatf("t1_im_addr_u%0d", k), 32'(im_addr[k]), 32'(i));
                check($sformatf("t1_d_valid_u%0d", k), 32'(d_valid[k]), 32'(i >= 2));
            end
            tick();
        end

        // D stalls: fetch stops with exactly QD entries buffered, then drains without loss.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t2_im_en_full_u%0d", k), 32'(im_en[k]), 32'd0);
            check($sformatf("t2_fill_depth_u%0d", k), 32'(im_addr[k]),
                  (m_seq[k] + 32'(4 * QD) - BASE) >> 2);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, '0);
            tick();
        end

        // Redirect against a full queue with no pop.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b1, 32'h0000_3100);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, '0);
            tick();
        end

        // Redirect with empty queue and a fetch in flight.
        do_reset();
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_3200);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, '0);
            tick();
        end

        // Redirect with nothing fetched yet, then a misaligned redirect while the slot is owed.
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_3300);
        tick();
        drive(1'b1, 1'b1, 32'h0000_3402);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, '0);
            tick();
        end

        // Redirect past the end of the ROM: nops delivered, ROM not enabled.
        drive(1'b1, 1'b1, 32'h0000_7000);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, '0);
            if (i >= 3) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("t5_im_en_oor_u%0d", k), 32'(im_en[k]), 32'd0);
                end
            end
            tick();
        end

        // Reset mid-stream with the queue filling, then restart from the base PC.
        drive(1'b1, 1'b1, 32'h0000_3040);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0);
            tick();
        end
        drive(1'b0, 1'b0, '0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, '0);
            if (i == 0) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("t6_restart_addr_u%0d", k), 32'(im_addr[k]), 32'd0);
                    check($sformatf("t6_restart_en_u%0d", k), 32'(im_en[k]), 32'd1);
                end
            end
            tick();
        end

        // Randomised traffic: stalls, redirects in and out of the ROM window, misaligned targets.
        for (int n = 0; n < 800; n++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] t;
            int          sel;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 7) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       t = BASE + 32'($urandom_range(0, 4095) << 2);
            else if (sel == 7) t = BASE + 32'($urandom_range(0, 16383));
            else if (sel == 8) t = 32'h0000_6FF0 + 32'($urandom_range(0, 3) << 2);
            else               t = ($urandom_range(0, 1) != 0) ? 32'h0000_0100 : 32'h0000_8000;
            drive(rdy, rd, t);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
